// File: rtl/uart_tx_serializer.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer with registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   tx_data,
  input  logic                          txValid,
  output logic                          txReady,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [15:0]   baud_cnt, baud_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          txd_next;
  logic          push, pop, baud_tc, fifo_empty;
  logic          unused_tx_data_hi;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit, parity_next;
`endif

  assign unused_tx_data_hi = ^tx_data[31:8];

  assign fifo_empty = (level == '0);
  assign txReady    = (level != FULL_LEVEL);
  assign push       = txValid && txReady;
  assign baud_tc    = (baud_cnt == BAUD_LAST);
  assign fifo_level = level;
  assign busy       = (state != IDLE) || !fifo_empty;

  // Storage is not reset; level and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= tx_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      uart_txd <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      uart_txd <= txd_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_next;
`endif
    end
  end

  // The line value is derived from the next state so the start bit appears on the loading edge.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    pop           = 1'b0;
    txd_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_bit;
`endif

    if (state != IDLE) begin
      baud_cnt_next = baud_tc ? 16'd0 : baud_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          shreg_next    = mem[rd_ptr];
          bit_idx_next  = '0;
          baud_cnt_next = '0;
          state_next    = START;
`ifdef UART_TX_PARITY_EN
          parity_next   = ^mem[rd_ptr];
`endif
        end
      end
      START: begin
        if (baud_tc) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = {1'b0, shreg[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tc) begin
          if (!fifo_empty) begin
            pop          = 1'b1;
            shreg_next   = mem[rd_ptr];
            bit_idx_next = '0;
            state_next   = START;
`ifdef UART_TX_PARITY_EN
            parity_next  = ^mem[rd_ptr];
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
      end
    endcase

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_next = parity_next;
`endif
      default: txd_next = 1'b1;
    endcase
  end

endmodule
